// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serialises icache/dcache word requests onto one RAM port, dcache first,
// with a RAM-timeout watchdog. Define ISTARVE_LIMIT_EN to bound consecutive d-grants while i waits.
module mem_arbiter #(
    parameter int TIMEOUT     = 255,
    parameter int ISTARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    localparam logic [31:0] ABORT_WORD = 32'hBAD1BAD1;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        busy, done, tmo, grant_d, grant_i, force_i;

`ifdef ISTARVE_LIMIT_EN
    logic [15:0] starve;

    assign force_i = iREN && (starve == 16'(ISTARVE_MAX));

    // Counts back-to-back d-grants that left a pending i-request behind.
    always_ff @(posedge CLK) begin
        if (!nRST)
            starve <= '0;
        else if (grant_i)
            starve <= '0;
        else if (grant_d)
            starve <= iREN ? starve + 16'd1 : 16'd0;
    end
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        busy      = (state != IDLE);
        done      = busy && ramready;
        tmo       = busy && !ramready && (cnt == TMO_LAST);
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        state_nxt = state;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !force_i) begin
                    grant_d   = 1'b1;
                    state_nxt = DACC;
                end else if (iREN) begin
                    grant_i   = 1'b1;
                    state_nxt = IACC;
                end
            end
            IACC: begin
                if (done || tmo) begin
                    state_nxt = IDLE;
                    iwait     = 1'b0;
                    iload     = done ? ramload : ABORT_WORD;
                end
            end
            DACC: begin
                if (done || tmo) begin
                    state_nxt = IDLE;
                    dwait     = 1'b0;
                    dload     = done ? ramload : ABORT_WORD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                ramaddr  <= daddr;
                ramstore <= dstore;
                ramWEN   <= dWEN;
                ramREN   <= dREN && !dWEN;  // write wins when both are requested
                cnt      <= '0;
            end else if (grant_i) begin
                ramaddr <= iaddr;
                ramREN  <= 1'b1;
                ramWEN  <= 1'b0;
                cnt     <= '0;
            end else if (done || tmo) begin
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
            end else if (busy) begin
                cnt <= cnt + 16'd1;
            end
            if (tmo)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int TO   = 8;
    localparam int SMAX = 4;
    localparam logic [31:0] ABORT = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST, iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, err;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the RAM, how long it has waited, what was latched.
    int          m_owner;   // 0 none, 1 icache, 2 dcache
    int          m_age;     // access cycles elapsed, counting the current one
    int          m_starve;
    bit          m_err, m_ren, m_wen;
    logic [31:0] m_addr, m_store;

    mem_arbiter #(.TIMEOUT(TO), .ISTARVE_MAX(SMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks outputs against the model.
    task automatic settle();
        bit busy, done, to;
        #3;
        busy = (m_owner != 0);
        done = busy && ramready;
        to   = busy && !ramready && (m_age == TO);
        chk("ramREN", ramREN, m_ren);
        chk("ramWEN", ramWEN, m_wen);
        chk("err", err, m_err);
        chk("iwait", iwait, !(m_owner == 1 && (done || to)));
        chk("dwait", dwait, !(m_owner == 2 && (done || to)));
        chk("iload", iload, (m_owner == 1) ? (done ? ramload : (to ? ABORT : 32'h0)) : 32'h0);
        chk("dload", dload, (m_owner == 2) ? (done ? ramload : (to ? ABORT : 32'h0)) : 32'h0);
        if (m_ren || m_wen) chk("ramaddr", ramaddr, m_addr);
        if (m_wen) chk("ramstore", ramstore, m_store);
    endtask

    // Advance the model across the coming edge, then move to posedge+1.
    task automatic adv();
        bit busy, done, to, frc;
        busy = (m_owner != 0);
        done = busy && ramready;
        to   = busy && !ramready && (m_age == TO);
        if (!nRST) begin
            m_owner = 0; m_age = 0; m_starve = 0; m_err = 0;
            m_ren = 0; m_wen = 0; m_addr = 0; m_store = 0;
        end else if (busy) begin
            if (done || to) begin
                if (to) m_err = 1;
                m_owner = 0; m_ren = 0; m_wen = 0;
            end else begin
                m_age++;
            end
        end else begin
`ifdef ISTARVE_LIMIT_EN
            frc = iREN && (m_starve == SMAX);
`else
            frc = 0;
`endif
            if ((dREN || dWEN) && !frc) begin
                m_owner = 2; m_age = 1;
                m_wen = dWEN; m_ren = !dWEN;
                m_addr = daddr; m_store = dstore;
                m_starve = iREN ? m_starve + 1 : 0;
            end else if (iREN) begin
                m_owner = 1; m_age = 1;
                m_ren = 1; m_wen = 0; m_addr = iaddr;
                m_starve = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic quiet();
        iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    endtask

    initial begin
        logic [31:0] grants[$];
        logic [31:0] exp_g;
        int quiet_left;

        nRST = 0; quiet(); iREN = 1;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        m_owner = 0; m_age = 0; m_starve = 0; m_err = 0;
        m_ren = 0; m_wen = 0; m_addr = 0; m_store = 0;
        adv();  // first edge loads reset values; nothing defined before it

        // Reset held with an i-request pending
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("rst_ramREN", ramREN, 1'b0);
            chk("rst_iwait", iwait, 1'b1);
            chk("rst_err", err, 1'b0);
            chk("rst_ramaddr", ramaddr, 32'h0);
            adv();
        end

        // Instruction read, RAM answers two cycles after the strobe
        nRST = 1; iREN = 1; iaddr = 32'h40; ramload = 32'hDEADBEEF;
        cyc();
        cyc();
        settle(); chk("iread_wait_early", iwait, 1'b1); adv();
        ramready = 1;
        settle();
        chk("iread_addr", ramaddr, 32'h40);
        chk("iread_iwait", iwait, 1'b0);
        chk("iread_iload", iload, 32'hDEADBEEF);
        adv();
        quiet(); cyc();

        // Simultaneous i-read and d-write: write goes first
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        cyc();
        ramready = 1;
        settle();
        chk("conf_wen", ramWEN, 1'b1);
        chk("conf_store", ramstore, 32'h1234);
        chk("conf_iwait", iwait, 1'b1);
        adv();
        dWEN = 0; ramready = 0;
        cyc();
        ramready = 1; ramload = 32'h0BADF00D;
        settle();
        chk("conf_iaddr", ramaddr, 32'h44);
        chk("conf_iwait_done", iwait, 1'b0);
        adv();
        quiet(); cyc();

        // Watchdog: RAM never responds
        dREN = 1; daddr = 32'h100;
        cyc();
        for (int k = 1; k < TO; k++) begin
            settle(); chk("tmo_dwait_hold", dwait, 1'b1); adv();
        end
        settle();
        chk("tmo_dwait", dwait, 1'b0);
        chk("tmo_dload", dload, ABORT);
        adv();
        dREN = 0; iREN = 1; iaddr = 32'h48;
        settle(); chk("tmo_err", err, 1'b1); adv();
        ramready = 1; ramload = 32'h600DC0DE;
        settle();
        chk("after_tmo_iload", iload, 32'h600DC0DE);
        chk("after_tmo_err", err, 1'b1);
        adv();
        quiet(); cyc();

        // Reset in the middle of a d-access
        dREN = 1; daddr = 32'h200;
        cyc();
        nRST = 0;
        cyc();
        nRST = 1; dREN = 0;
        settle();
        chk("midrst_ren", ramREN, 1'b0);
        chk("midrst_dwait", dwait, 1'b1);
        chk("midrst_err", err, 1'b0);
        adv();

        // Both sides requesting continuously; RAM answers every cycle
        dREN = 1; daddr = 32'hD0; iREN = 1; iaddr = 32'h10; ramready = 1;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (ramREN || ramWEN) grants.push_back(ramaddr);
            adv();
        end
        chk("starve_count", grants.size(), 10);
        for (int k = 0; k < grants.size() && k < 10; k++) begin
`ifdef ISTARVE_LIMIT_EN
            exp_g = (k % (SMAX + 1) == SMAX) ? 32'h10 : 32'hD0;
`else
            exp_g = 32'hD0;
`endif
            chk("starve_order", grants[k], exp_g);
        end
        quiet(); cyc();

        // Randomized traffic, occasional resets and RAM stalls
        quiet_left = 0;
        for (int n = 0; n < 3000; n++) begin
            nRST   = ($urandom_range(0, 199) != 0);
            iREN   = ($urandom_range(0, 2) != 0);
            dREN   = ($urandom_range(0, 2) == 0);
            dWEN   = ($urandom_range(0, 3) == 0);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            if (quiet_left > 0) begin
                ramready = 0;
                quiet_left--;
            end else begin
                ramready = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 39) == 0) quiet_left = 12;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
